// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state encoding and helpers for the serial shift-register link
package tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } tx_state_e;

    // Counter width for a count of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// rtl/piso_serial_tx_if.sv - load handshake and serial output bundle of the transmitter
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             bit_strobe;
    logic             done;

    // Producer side: offers words, observes the serial line.
    modport master (
        output data_in, load_valid,
        input  load_ready, sout, sout_valid, bit_strobe, done
    );

    // Transmitter side.
    modport slave (
        input  data_in, load_valid,
        output load_ready, sout, sout_valid, bit_strobe, done
    );
endinterface

// File: rtl/bit_period_ctr.sv
// rtl/bit_period_ctr.sv - clocks-per-bit counter with first/last clock flags
module bit_period_ctr
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic strobe,
    output logic last
);
    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign strobe = (count_q == '0);
    assign last   = (count_q == TERM);

    // Next count: clear wins, otherwise count up and wrap at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/piso_serial_tx.sv
// rtl/piso_serial_tx.sv - parallel-in serial-out transmitter: FSM, shift register, bit counter
module piso_serial_tx
    import tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serial_tx_if.slave    tx
);
    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             load_ready_q, load_ready_d;
    logic             done_q, done_d;

    logic             ctr_clr;
    logic             ctr_strobe;
    logic             ctr_last;
    logic             handshake;
    logic [WIDTH-1:0] shreg_adv;

    assign handshake = tx.load_valid && load_ready_q;
    assign shreg_adv = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                 : {shreg_q[WIDTH-2:0], 1'b0};

    bit_period_ctr #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_period_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ctr_clr),
        .en     (state_q == S_SHIFT),
        .strobe (ctr_strobe),
        .last   (ctr_last)
    );

    // Next-state, shift and bit-count logic; outputs are derived from the next
    // state so that they appear on the same cycle the state is entered.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ctr_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d   = S_SHIFT;
                    shreg_d   = tx.data_in;
                    bit_cnt_d = '0;
                    ctr_clr   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (ctr_last) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_adv;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        load_ready_d = (state_d == S_IDLE);
        sout_valid_d = (state_d == S_SHIFT);
        done_d       = (state_d == S_DONE);
        if (state_d == S_SHIFT) begin
            sout_d = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
        end else begin
            sout_d = IDLE_LEVEL;
        end
    end

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            load_ready_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            load_ready_q <= load_ready_d;
            done_q       <= done_d;
        end
    end

    assign tx.sout       = sout_q;
    assign tx.sout_valid = sout_valid_q;
    assign tx.load_ready = load_ready_q;
    assign tx.done       = done_q;
    // The counter sits at zero on the first clock of every bit.
    assign tx.bit_strobe = sout_valid_q && ctr_strobe;
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb/tb_piso_serial_tx.sv - directed and random scoreboard bench for piso_serial_tx
module tb_piso_serial_tx;
    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    piso_serial_tx_if #(.WIDTH(8)) if_a ();
    piso_serial_tx_if #(.WIDTH(8)) if_b ();

    piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .tx    (if_a.slave)
    );

    piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .tx    (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get(input bit sel, output logic s, output logic sv, output logic bs,
                       output logic lr, output logic dn);
        if (sel) begin
            s = if_b.sout; sv = if_b.sout_valid; bs = if_b.bit_strobe;
            lr = if_b.load_ready; dn = if_b.done;
        end else begin
            s = if_a.sout; sv = if_a.sout_valid; bs = if_a.bit_strobe;
            lr = if_a.load_ready; dn = if_a.done;
        end
    endtask

    task automatic check_idle(input string tag, input bit sel);
        logic s, sv, bs, lr, dn;
        get(sel, s, sv, bs, lr, dn);
        check({tag, "_sout"}, 32'(s), 32'd1);
        check({tag, "_sout_valid"}, 32'(sv), 32'd0);
        check({tag, "_bit_strobe"}, 32'(bs), 32'd0);
        check({tag, "_load_ready"}, 32'(lr), 32'd1);
        check({tag, "_done"}, 32'(dn), 32'd0);
    endtask

    // Called just after a negedge: offers a word, records it, advances to cycle N+1.
    task automatic start(input bit sel, input logic [7:0] w);
        logic s, sv, bs, lr, dn;
        if (sel) begin if_b.data_in = w; if_b.load_valid = 1'b1; end
        else     begin if_a.data_in = w; if_a.load_valid = 1'b1; end
        get(sel, s, sv, bs, lr, dn);
        check("start_load_ready", 32'(lr), 32'd1);
        if (sel) q_b.push_back(w); else q_a.push_back(w);
        @(negedge clk);
    endtask

    // Checks cycles N+1 .. N+2+8*CPB; returns at the negedge where load_ready is back.
    task automatic check_frame(input bit sel, input logic [7:0] w);
        logic s, sv, bs, lr, dn;
        int cpb;
        int idx;
        cpb = sel ? 1 : 4;
        for (int i = 0; i < 8; i++) begin
            idx = sel ? i : 7 - i;
            for (int c = 0; c < cpb; c++) begin
                get(sel, s, sv, bs, lr, dn);
                check("frame_sout", 32'(s), 32'(w[idx]));
                check("frame_sout_valid", 32'(sv), 32'd1);
                check("frame_bit_strobe", 32'(bs), (c == 0) ? 32'd1 : 32'd0);
                check("frame_load_ready", 32'(lr), 32'd0);
                check("frame_done", 32'(dn), 32'd0);
                @(negedge clk);
            end
        end
        get(sel, s, sv, bs, lr, dn);
        check("done_pulse", 32'(dn), 32'd1);
        check("done_sout", 32'(s), 32'd1);
        check("done_sout_valid", 32'(sv), 32'd0);
        check("done_load_ready", 32'(lr), 32'd0);
        @(negedge clk);
        get(sel, s, sv, bs, lr, dn);
        check("ready_back", 32'(lr), 32'd1);
        check("ready_done_low", 32'(dn), 32'd0);
        check("ready_sout_valid", 32'(sv), 32'd0);
    endtask

    // Receiving SIPO models: capture sout on bit_strobe, compare against scoreboard on done.
    logic [7:0] rx_a, rx_b;
    int nb_a, nb_b;
    logic [7:0] exp_a, exp_b;

    always @(negedge clk) begin
        if (!rst_n_a) begin
            rx_a = '0; nb_a = 0;
        end else begin
            if (if_a.bit_strobe) begin rx_a = {rx_a[6:0], if_a.sout}; nb_a++; end
            if (if_a.done) begin
                if (q_a.size() == 0) begin
                    check("a_done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_a = q_a.pop_front();
                    check("a_rx_word", 32'(rx_a), 32'(exp_a));
                    check("a_rx_bits", 32'(nb_a), 32'd8);
                end
                nb_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n_b) begin
            rx_b = '0; nb_b = 0;
        end else begin
            if (if_b.bit_strobe) begin rx_b = {if_b.sout, rx_b[7:1]}; nb_b++; end
            if (if_b.done) begin
                if (q_b.size() == 0) begin
                    check("b_done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_b = q_b.pop_front();
                    check("b_rx_word", 32'(rx_b), 32'(exp_b));
                    check("b_rx_bits", 32'(nb_b), 32'd8);
                end
                nb_b = 0;
            end
        end
    end

    initial begin
        logic s, sv, bs, lr, dn;
        logic [7:0] w;
        int waited;

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        if_a.data_in = '0; if_a.load_valid = 1'b0;
        if_b.data_in = '0; if_b.load_valid = 1'b0;

        // Reset values while rst_n is held low.
        #15;
        check_idle("rst_a", 1'b0);
        check_idle("rst_b", 1'b1);
        #5;
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);
        check_idle("post_rst_a", 1'b0);

        // MSB-first A5, four clocks per bit.
        start(1'b0, 8'hA5);
        if_a.load_valid = 1'b0;
        check_frame(1'b0, 8'hA5);

        // LSB-first 01, one clock per bit.
        start(1'b1, 8'h01);
        if_b.load_valid = 1'b0;
        check_frame(1'b1, 8'h01);

        // load_valid held high while data_in changes: 3C goes out, FF waits for ready.
        start(1'b0, 8'h3C);
        if_a.data_in = 8'hFF;
        check_frame(1'b0, 8'h3C);
        start(1'b0, 8'hFF);
        if_a.load_valid = 1'b0;
        check_frame(1'b0, 8'hFF);

        // Reset during bit 3 aborts the frame with no done pulse.
        @(negedge clk);
        start(1'b0, 8'h5A);
        if_a.load_valid = 1'b0;
        repeat (13) @(negedge clk);
        get(1'b0, s, sv, bs, lr, dn);
        check("mid_frame_valid", 32'(sv), 32'd1);
        rst_n_a = 1'b0;
        #1;
        check_idle("abort", 1'b0);
        q_a.delete();
        repeat (3) begin
            @(negedge clk);
            get(1'b0, s, sv, bs, lr, dn);
            check("abort_no_done", 32'(dn), 32'd0);
        end
        rst_n_a = 1'b1;
        @(negedge clk);
        start(1'b0, 8'h81);
        if_a.load_valid = 1'b0;
        check_frame(1'b0, 8'h81);

        // Random round-trip through the SIPO models.
        for (int k = 0; k < 120; k++) begin
            bit sel;
            sel = (k >= 100);
            w = 8'($urandom());
            @(negedge clk);
            start(sel, w);
            if (sel) if_b.load_valid = 1'b0; else if_a.load_valid = 1'b0;
            waited = 0;
            get(sel, s, sv, bs, lr, dn);
            while (!lr && waited < 60) begin
                @(negedge clk);
                waited++;
                get(sel, s, sv, bs, lr, dn);
            end
            check("rand_ready_return", 32'(lr), 32'd1);
        end

        @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
